// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM control unit and its datapath.
package mc_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction-field inputs and control outputs between datapath and control unit.
interface multicycle_control_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic       RegWrite;
  logic [3:0] State;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, State
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, State
  );
endinterface

// File: rtl/cond_unit.sv
// NZCV flag registers and condition-field evaluation against the stored flags.
module cond_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       FlagEn,
  output logic       CondEx
);
  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       n, z, c, v;

  assign {n, z} = nz_q;
  assign {c, v} = cv_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

  // A failed condition also blocks the flag update of its own instruction
  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (FlagEn && CondEx && FlagW[1]) nz_d = ALUFlags[3:2];
    if (FlagEn && CondEx && FlagW[0]) cv_d = ALUFlags[1:0];
  end

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = ~(n ^ v);
      4'b1011: CondEx = n ^ v;
      4'b1100: CondEx = ~z & ~(n ^ v);
      4'b1101: CondEx = z | (n ^ v);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute/memory/writeback
// and gates architectural writes on the condition field.
module multicycle_control
  import mc_pkg::*;
(
  input logic                 CLK,
  input logic                 RST,
  multicycle_control_if.slave bus
);
  state_e     state_q, state_d;
  logic       ir_w, reg_w, mem_w, branch, alu_wb;
  logic       adr_src, alu_src_a;
  logic [1:0] res_src, alu_src_b, alu_ctl;
  logic [1:0] dec_alu;
  logic       dec_nowrite;
  logic [1:0] flag_w;
  logic       cond_ex, flag_en, reg_write;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Data-processing command decode; unknown commands neither write nor set flags
  always_comb begin
    dec_alu     = ALU_ADD;
    dec_nowrite = 1'b1;
    flag_w      = 2'b00;
    case (bus.Funct[4:1])
      CMD_ADD: begin dec_alu = ALU_ADD; dec_nowrite = 1'b0; flag_w = {2{bus.Funct[0]}}; end
      CMD_SUB: begin dec_alu = ALU_SUB; dec_nowrite = 1'b0; flag_w = {2{bus.Funct[0]}}; end
      CMD_AND: begin dec_alu = ALU_AND; dec_nowrite = 1'b0; flag_w = {bus.Funct[0], 1'b0}; end
      CMD_ORR: begin dec_alu = ALU_ORR; dec_nowrite = 1'b0; flag_w = {bus.Funct[0], 1'b0}; end
      CMD_CMP: begin dec_alu = ALU_SUB; dec_nowrite = 1'b1; flag_w = {2{bus.Funct[0]}}; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = S_FETCH;
    ir_w      = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_wb    = 1'b0;
    adr_src   = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RD2;
    alu_ctl   = ALU_ADD;
    res_src   = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        ir_w = 1'b1; alu_src_a = 1'b1; alu_src_b = SRCB_FOUR; res_src = RES_ALURESULT;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 1'b1; alu_src_b = SRCB_FOUR; res_src = RES_ALURESULT;
        case (bus.Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = SRCB_IMM;
        state_d   = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD:  begin adr_src = 1'b1; state_d = S_MEMWB; end
      S_MEMWB:  begin res_src = RES_DATA; reg_w = 1'b1; end
      S_MEMWR:  begin adr_src = 1'b1; mem_w = 1'b1; end
      S_EXECR:  begin alu_ctl = dec_alu; state_d = S_ALUWB; end
      S_EXECI:  begin alu_src_b = SRCB_IMM; alu_ctl = dec_alu; state_d = S_ALUWB; end
      S_ALUWB:  begin reg_w = 1'b1; alu_wb = 1'b1; end
      S_BRANCH: begin alu_src_b = SRCB_IMM; res_src = RES_ALURESULT; branch = 1'b1; end
      default:  ;
    endcase
  end

  cond_unit u_cond (
    .CLK      (CLK),
    .RST      (RST),
    .Cond     (bus.Cond),
    .ALUFlags (bus.ALUFlags),
    .FlagW    (flag_w),
    .FlagEn   (flag_en),
    .CondEx   (cond_ex)
  );

  assign flag_en   = (state_q == S_EXECR) || (state_q == S_EXECI);
  assign reg_write = reg_w & cond_ex & ~(alu_wb & dec_nowrite);

  // Write strobes drop combinationally while reset is held
  assign bus.RegWrite   = reg_write & ~RST;
  assign bus.MemWrite   = mem_w & cond_ex & ~RST;
  assign bus.IRWrite    = ir_w & ~RST;
  assign bus.PCWrite    = ~RST & ((state_q == S_FETCH) | (branch & cond_ex) |
                                  (reg_write & (bus.Rd == 4'd15)));
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = res_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
  assign bus.State      = state_q;
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control unit for the multicycle variant of the ARM calculator core. It decodes the instruction held in the datapath's instruction register and steps a shared memory/ALU datapath through fetch, decode, execute, memory and writeback cycles. It also holds the NZCV condition flags and gates every architectural write on the instruction's condition field. It sits beside the existing datapath blocks (register file, ALU, extend unit, PC register, unified instruction/data memory) and replaces the single-cycle combinational decoder.

## Interface
Parameters: none.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- Cond  in  4  Instr[31:28].
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20].
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  ALU {N,Z,C,V} for the current cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register enable.
- ResultSrc  out  2  result mux select: 00 = ALUOut register, 01 = data register, 10 = ALUResult.
- ALUSrcA  out  1  ALU A operand: 0 = RD1, 1 = PC.
- ALUSrcB  out  2  ALU B operand: 00 = RD2, 01 = ExtImm, 10 = constant 4.
- ALUControl  out  2  ALU operation: 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- ImmSrc  out  2  equal to Op.
- RegSrc  out  2  register read selects: [0] = (Op==10), [1] = (Op==01).
- RegWrite  out  1  register file write strobe.
- State  out  4  current FSM state, for debug.

## Operation
FSM states, 4-bit encoding:
- FETCH = 0: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next: DECODE.
- DECODE = 1: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. This produces PC+8 for R15 reads. Next state by Op:
  - Op=01: MEMADR.
  - Op=00, Funct[5]=0: EXECR.
  - Op=00, Funct[5]=1: EXECI.
  - Op=10: BRANCH.
  - Op=11: FETCH (treated as a NOP).
- MEMADR = 2: ALUSrcA=0, ALUSrcB=01, ADD. Next: MEMRD if Funct[0]=1, else MEMWR.
- MEMRD = 3: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB = 4: ResultSrc=01, RegW. Next: FETCH.
- MEMWR = 5: AdrSrc=1, MemW. Next: FETCH.
- EXECR = 6: ALUSrcA=0, ALUSrcB=00, ALU decode. Next: ALUWB.
- EXECI = 7: ALUSrcA=0, ALUSrcB=01, ALU decode. Next: ALUWB.
- ALUWB = 8: ResultSrc=00, RegW. Next: FETCH.
- BRANCH = 9: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, Branch. Next: FETCH.
- Encodings 10–15: next state FETCH, all strobes 0.

ALU decode, using Funct[4:1]. Data-processing commands follow the decode recorded in ALUWB, so NoWrite applies at ALUWB.
- 0100 ADD → 00.
- 0010 SUB → 01.
- 0000 AND → 10.
- 1100 ORR → 11.
- 1010 CMP → 01 with NoWrite.
- Any other command → 00 with NoWrite and no flag write.

Flags:
- FlagW[1] (NZ update) = Funct[0].
- FlagW[0] (CV update) = Funct[0] & (ADD|SUB|CMP).

Condition check:
- CondEx is evaluated from the registered flags against Cond, covering the full ARM set 0000–1110. Cond 1111 gives CondEx = 0.
- Flags update only at the rising edge that ends EXECR/EXECI, and only when FlagW & CondEx.

Gated outputs:
- RegWrite = RegW & CondEx & ~NoWrite.
- MemWrite = MemW & CondEx.
- PCWrite = FETCH | (Branch & CondEx) | (RegWrite & Rd==15).

## Timing
- Outputs are combinational from State, the instruction fields and the flags. There is no output register.
- Cycles per instruction:
  - LDR: 5.
  - STR: 4.
  - Data-processing: 4.
  - Branch: 3.
  - Op=11: 2.
- Flags written in cycle N are visible to CondEx in cycle N+1. The next instruction's condition check always sees them.
- A failed condition still walks the full state path. All write strobes stay 0, and PCWrite is asserted only in FETCH.
- An LDR to R15 (Rd=15) asserts both RegWrite and PCWrite in MEMWB.
- Reset behaviour:
  - While RST=1: State = FETCH, flags = 0000.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 while RST=1. Muxes show FETCH values.
  - RST asserted in any state aborts the instruction immediately, with no write.
  - The first FETCH executes on the first rising edge after RST deasserts.

## Structure
- Shared package mc_pkg holds:
  - state encodings;
  - ALUControl codes;
  - Op codes;
  - ResultSrc and ALUSrcB codes, shared with the datapath.
- Sub-module cond_unit holds the NZ and CV flag registers and the CondEx evaluation. Its ports are CLK, RST, Cond, ALUFlags, FlagW and an update enable.

## Test plan
- Reset: hold RST for 3 cycles → State=0 and all four strobes 0. Release → IRWrite=1 and PCWrite=1 on the first edge, State=1 on the next.
- ADD R1,R2,#5 (E2821005) → states 0,1,7,8. ALUControl=00 in EXECI. RegWrite=1 only in ALUWB.
- SUBS setting Z, then BEQ → Z=1 after EXECR. BRANCH asserts PCWrite=1. Repeat with BNE → PCWrite=0 in BRANCH.
- CMP R0,R0 (E1500000) → flags 0110, RegWrite never 1. Next ADDNE → RegWrite=0.
- LDR (E5910000) → states 0,1,2,3,4, RegWrite in MEMWB. STR (E5810000) → 0,1,2,5, MemWrite=1 in MEMWR only.
- RST asserted mid-MEMWR → MemWrite drops to 0 asynchronously and State returns to 0.
